// File: rtl/mu0_sequencer.sv
// MU0/ARM-hybrid fetch/execute sequencer: owns PC and IR', drives exec1/exec2 strobes, honours SKIP, halts on STP.
// Optional single-step gating of instruction fetch is enabled with `define SEQ_SINGLE_STEP_EN.
module mu0_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] memdata,
  input  logic        memrdy,
  output logic [15:0] memaddr,
  output logic        memrd,
  output logic        memwr,
  output logic [15:0] ir,
  output logic        exec1,
  output logic        exec2,
  input  logic        skipstatus,
  output logic        skipclr,
  input  logic        accmi,
  input  logic        acczero,
  output logic [15:0] pcout,
  output logic        halted
`ifdef SEQ_SINGLE_STEP_EN
  ,
  input  logic        step
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  logic        is_arm;
  logic [3:0]  opc;
  logic [15:0] opnd;
  logic        is_sta;
  logic        fetch_en;
  logic        fetch_acc;

  assign is_arm    = (ir_q[15:14] == 2'b11);
  assign opc       = ir_q[15:12];
  assign opnd      = {4'h0, ir_q[11:0]};
  assign is_sta    = (opc == 4'b0001);
  assign fetch_acc = (state_q == S_FETCH) && fetch_en && memrdy;

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic armed_q, armed_d;

  // A step edge arriving on the same cycle as an accept re-arms for the next fetch.
  assign armed_d  = (armed_q & ~fetch_acc) | (step & ~step_q);
  assign fetch_en = armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= step;
      armed_q <= armed_d;
    end
  end
`else
  assign fetch_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_acc) begin
          pc_d = pc_q + 16'd1;
          // A skipped word is consumed but never reaches IR'.
          if (!skipstatus) begin
            ir_d    = memdata;
            state_d = S_EXEC1;
          end
        end
      end
      S_EXEC1: begin
        state_d = S_FETCH;
        if (!is_arm) begin
          case (opc)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: state_d = S_EXEC2;
            4'b0100: pc_d = opnd;
            4'b0101: if (accmi)   pc_d = opnd;
            4'b0110: if (acczero) pc_d = opnd;
            4'b0111: state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC2: begin
        if (memrdy) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memaddr = (state_q == S_EXEC2) ? opnd : pc_q;
    memrd   = 1'b0;
    memwr   = 1'b0;
    exec1   = 1'b0;
    exec2   = 1'b0;
    skipclr = 1'b0;
    // Reset masks every request and strobe immediately, abandoning any pending transfer.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memrd   = fetch_en;
          skipclr = fetch_en & memrdy & skipstatus;
        end
        S_EXEC1: exec1 = 1'b1;
        S_EXEC2: begin
          memrd = ~is_sta;
          memwr = is_sta;
          exec2 = memrdy;
        end
        default: ;
      endcase
    end
  end

  assign ir     = ir_q;
  assign pcout  = pc_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: doc/mu0_sequencer.md
# mu0_sequencer

Instruction fetch/execute sequencer for the MU0/ARM-hybrid CPU. It is the upstream partner of the ALU block:
- fetches 16-bit words from memory over a ready handshake;
- holds the instruction register that drives the ALU's `instruction` input (IR');
- generates the `exec1`/`exec2` timing strobes;
- consumes the ALU's SKIP status to discard the following instruction;
- owns the PC, resolves MU0 jumps and halts on STP.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memdata`  in  16  memory read data, valid when `memrdy`=1.
- `memrdy`  in  1  memory ready; a transfer completes on an edge where `memrdy`=1 and `memrd`|`memwr`=1.
- `memaddr`  out  16  memory address.
- `memrd`  out  1  memory read request.
- `memwr`  out  1  memory write request (data supplied by datapath).
- `ir`  out  16  instruction register (IR'), to ALU `instruction`.
- `exec1`  out  1  first execute strobe, to ALU `exec1`.
- `exec2`  out  1  memory-operand completion strobe for MU0 LDA/STA/ADD/SUB.
- `skipstatus`  in  1  Q of SKIP flip-flop.
- `skipclr`  out  1  synchronous clear for SKIP flip-flop.
- `accmi`  in  1  accumulator negative (bit 15).
- `acczero`  in  1  accumulator equals zero.
- `pcout`  out  16  current PC.
- `halted`  out  1  high in HALT state.
- `step`  in  1  single-step request (only with `SEQ_SINGLE_STEP_EN`).

## Operation
- States: FETCH, EXEC1, EXEC2, HALT.
- Format decode:
  - ARM format when `ir[15:14]`=2'b11.
  - Otherwise MU0: opcode `ir[15:12]`, operand S=`ir[11:0]` zero-extended to 16 bits.
- FETCH:
  - `memaddr`=PC, `memrd`=1.
  - Waits while `memrdy`=0.
  - On accept edge with `skipstatus`=0: `ir`<=`memdata`, PC<=PC+1, go EXEC1.
  - On accept edge with `skipstatus`=1: word discarded, `ir` unchanged, PC<=PC+1, remain FETCH. `skipclr` = FETCH & `memrdy` & `skipstatus` (combinational, same cycle as the accept).
- EXEC1: `exec1`=1 for exactly one cycle, then, by instruction:
  - ARM format, LDI (1000), LSL (1001), LSR (1010), undefined 1011: go FETCH.
  - LDA (0000), STA (0001), ADD (0010), SUB (0011): go EXEC2.
  - JMP (0100): PC<=S. JMI (0101): PC<=S if `accmi`. JEQ (0110): PC<=S if `acczero`. All three then go FETCH; flags are sampled on the EXEC1 edge.
  - STP (0111): go HALT.
- EXEC2:
  - `memaddr`=S; `memrd`=1 (LDA/ADD/SUB) or `memwr`=1 (STA).
  - Waits while `memrdy`=0.
  - `exec2` = EXEC2 & `memrdy`.
  - On completion edge go FETCH.
- HALT:
  - `halted`=1; no memory requests; `memaddr`=PC.
  - Left only by reset.
- PC arithmetic is modulo 2^16: 16'hFFFF+1 wraps to 16'h0000.
- Jump target S is 12-bit zero-extended; upper PC bits are cleared.

## Timing
- Reset edge loads: state FETCH, PC=`RESET_PC`, `ir`=16'h0000, `halted`=0.
- While `reset`=1: `memrd`, `memwr`, `exec1`, `exec2` and `skipclr` are forced 0.
- Reset asserted in any state, including mid-EXEC2 with a pending request, abandons the operation. Requests are gated off immediately by the reset forcing.
- With `memrdy` tied 1:
  - ARM/LDI/LSL/LSR/jump: 2 cycles per instruction.
  - LDA/STA/ADD/SUB: 3 cycles.
  - Skipped word: 1 cycle.
- Each wait cycle with `memrdy`=0 adds exactly one cycle. Outputs hold stable during a wait.
- The ALU writes CARRY/SKIP on the `exec1` cycle edge. The next FETCH therefore sees the updated `skipstatus`, with no extra bubble.
- `skipstatus` asserted during a wait is evaluated only on the accept edge.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - The `step` port exists.
  - A rising level of `step` sets an internal armed flag.
  - FETCH asserts `memrd` only while armed; the flag clears on the instruction-accept edge. Skipped words also consume the arm.
  - Reset clears the flag.
- Undefined: no `step` port; FETCH free-runs.

## Test plan
- `RESET_PC`=16'h0010, release reset, `memrdy`=1, `memdata`=16'hC000 -> `memaddr`=16'h0010 with `memrd`=1; then `ir`=16'hC000, single-cycle `exec1`, `pcout`=16'h0011, next fetch at 16'h0011.
- Fetch 16'h0123 (LDA 0x123), hold `memrdy`=0 for 3 EXEC2 cycles -> `memaddr`=16'h0123 with `memrd`=1 for 4 cycles; `exec2` high only in the `memrdy`=1 cycle; next fetch at PC+1. Repeat with 16'h1045 -> `memwr`=1, `memaddr`=16'h0045.
- Fetch 16'h6200 (JEQ) with `acczero`=1 -> next fetch at 16'h0200. With `acczero`=0 -> PC+1. Same pair with 16'h5200 (JMI) and `accmi`.
- `skipstatus`=1 while fetching at 16'h0005 -> `skipclr`=1 on the accept cycle, no `exec1`, next fetch at 16'h0006, `ir` unchanged.
- PC=16'hFFFF fetching an ARM word -> `pcout` wraps to 16'h0000.
- Fetch 16'h7000 (STP) -> `halted`=1, `memrd`/`memwr`=0 for 20 cycles. Assert reset mid-EXEC2 of an LDA -> requests drop on the reset cycle, restart at `RESET_PC`.
